// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per programmable window and hands each rate out over valid/ready
module spike_rate_decoder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] window_len,
  input  logic         spike_in,
  output logic [W-1:0] rate_out,
  output logic         rate_valid,
  input  logic         rate_ready,
  output logic         overrun,
  output logic         busy
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state;
  logic [W-1:0] len_q, cyc, cnt, cnt_next;
  logic term, res, hs, load;
  always_comb begin
    cnt_next = (&cnt) ? cnt : cnt + W'(spike_in);
    term = cyc == len_q - W'(1);
    res = state == COUNT && term;
    hs = rate_valid && rate_ready;
    load = res && (!rate_valid || hs);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      len_q <= '0;
      cyc <= '0;
      cnt <= '0;
      rate_out <= '0;
      rate_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= enable ? COUNT : IDLE;
      busy <= enable;
      if (state == IDLE ? enable : enable && term) begin
        len_q <= window_len;
        cyc <= '0;
        cnt <= '0;
      end else if (state == COUNT) begin
        cyc <= cyc + W'(1);
        cnt <= cnt_next;
      end
      if (load) begin
        rate_out <= cnt_next;
        rate_valid <= 1'b1;
      end else if (hs) begin
        rate_valid <= 1'b0;
      end
      if (res && rate_valid && !rate_ready) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: vector table, directed corner sequences and random run against a window model
module tb_spike_rate_decoder;
  logic clk, rst, enable, spike_in, rate_ready;
  logic [7:0] window_len, rate_out;
  logic rate_valid, overrun, busy;
  int total, bad;
  int m_len, m_pos, m_cnt, m_out;
  bit m_run, m_vld, m_ovr;
  typedef struct {
    int len;
    logic [15:0] spk;
    int exp;
  } vec_t;
  vec_t vecs[7];
  int q[$];
  spike_rate_decoder #(.W(8)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .window_len(window_len),
    .spike_in(spike_in),
    .rate_out(rate_out),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun(overrun),
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  function automatic int wlen(int wl);
    return (wl % 256 == 0) ? 256 : wl % 256;
  endfunction
  function automatic void model_step(bit en, int wl, bit sp, bit rdy);
    bit have = 0;
    int res = 0;
    if (m_run) begin
      if (m_pos == m_len - 1) begin
        have = 1;
        res = (m_cnt + sp > 255) ? 255 : m_cnt + sp;
      end
      if (!en) m_run = 0;
      else if (have) begin
        m_len = wlen(wl);
        m_pos = 0;
        m_cnt = 0;
      end else begin
        m_pos++;
        m_cnt += sp;
      end
    end else if (en) begin
      m_run = 1;
      m_len = wlen(wl);
      m_pos = 0;
      m_cnt = 0;
    end
    if (have && (!m_vld || rdy)) begin
      m_out = res;
      m_vld = 1;
    end else if (have) m_ovr = 1;
    else if (m_vld && rdy) m_vld = 0;
  endfunction
  task automatic compare_all();
    chk("rate_out", rate_out, m_out);
    chk("rate_valid", rate_valid, m_vld);
    chk("overrun", overrun, m_ovr);
    chk("busy", busy, m_run);
  endtask
  task automatic tick(input bit en, input int wl, input bit sp, input bit rdy);
    enable = en;
    window_len = 8'(wl);
    spike_in = sp;
    rate_ready = rdy;
    model_step(en, wl, sp, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic do_reset();
    enable = 0;
    spike_in = 0;
    rate_ready = 0;
    rst = 1;
    m_run = 0; m_vld = 0; m_ovr = 0; m_out = 0; m_len = 0; m_pos = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 0;
    compare_all();
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst = 1; enable = 0; spike_in = 0; rate_ready = 0; window_len = 0;
    vecs[0] = '{10, 16'b0000_0010_0100_1000, 3};
    vecs[1] = '{4, 16'b1000, 1};
    vecs[2] = '{4, 16'b0101, 2};
    vecs[3] = '{1, 16'b1, 1};
    vecs[4] = '{1, 16'b0, 0};
    vecs[5] = '{16, 16'hFFFF, 16};
    vecs[6] = '{12, 16'hF000, 0};
    do_reset();
    chk("reset_out", rate_out, 0);
    chk("reset_valid", rate_valid, 0);
    chk("reset_busy", busy, 0);
    // spike on the enable cycle must be ignored; result lands len+1 cycles after enable is seen
    foreach (vecs[k]) begin
      do_reset();
      tick(1, vecs[k].len, 1, 1);
      for (int i = 0; i < vecs[k].len; i++) begin
        tick(i < vecs[k].len - 1, vecs[k].len, vecs[k].spk[i], 1);
        if (i == vecs[k].len - 2) chk("vec_early_valid", rate_valid, 0);
        if (i < vecs[k].len - 1) chk("vec_busy", busy, 1);
      end
      chk("vec_rate", rate_out, vecs[k].exp);
      chk("vec_valid", rate_valid, 1);
      tick(0, 0, 0, 1);
      chk("vec_pulse", rate_valid, 0);
    end
    do_reset();
    tick(1, 4, 0, 1);
    q.delete();
    for (int i = 0; i < 12; i++) begin
      tick(i < 11, 4, i % 2, 1);
      if (rate_valid) begin
        q.push_back(i);
        chk("b2b_rate", rate_out, 2);
      end
    end
    chk("b2b_count", q.size(), 3);
    if (q.size() == 3) begin
      chk("b2b_first", q[0], 3);
      chk("b2b_gap1", q[1] - q[0], 4);
      chk("b2b_gap2", q[2] - q[1], 4);
    end
    do_reset();
    tick(1, 0, 1, 1);
    for (int i = 0; i < 256; i++) begin
      tick(i < 255, 0, 1, 1);
      if (i == 254) begin
        chk("sat_early_valid", rate_valid, 0);
        chk("sat_busy", busy, 1);
      end
    end
    chk("sat_rate", rate_out, 255);
    chk("sat_valid", rate_valid, 1);
    do_reset();
    tick(1, 5, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(i < 9, 5, (i % 5) < 2, 0);
      if (i == 4) begin
        chk("bp_first", rate_out, 2);
        chk("bp_ovr_early", overrun, 0);
      end
    end
    chk("bp_held", rate_out, 2);
    chk("bp_valid", rate_valid, 1);
    chk("bp_ovr", overrun, 1);
    tick(0, 5, 0, 1);
    chk("bp_consumed", rate_valid, 0);
    chk("bp_out_hold", rate_out, 2);
    tick(0, 5, 0, 1);
    chk("bp_ovr_sticky", overrun, 1);
    do_reset();
    chk("bp_ovr_rst", overrun, 0);
    tick(1, 8, 0, 0);
    for (int i = 0; i < 8; i++) tick(1, 4, i < 7, 0);
    chk("hs_first", rate_out, 7);
    chk("hs_first_valid", rate_valid, 1);
    for (int i = 0; i < 4; i++) tick(i < 3, 4, 1, i == 3);
    chk("hs_load_out", rate_out, 4);
    chk("hs_load_valid", rate_valid, 1);
    chk("hs_load_ovr", overrun, 0);
    do_reset();
    tick(1, 10, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 10, 1, 1);
    tick(0, 10, 1, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", rate_valid, 0);
    for (int i = 0; i < 6; i++) tick(0, 10, 1, 1);
    chk("abort_no_result", rate_valid, 0);
    tick(1, 2, 0, 0);
    tick(1, 2, 1, 0);
    tick(1, 2, 1, 0);
    chk("rst_pending", rate_valid, 1);
    tick(1, 2, 1, 0);
    do_reset();
    chk("rst_out", rate_out, 0);
    chk("rst_valid", rate_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick($urandom_range(0, 15) != 0,
                ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 12)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Reads the 1-bit spike train produced by a neuron and decodes it back into an unsigned rate value: the number of spikes per programmable observation window.
- Sits downstream of the neuron array, on the output side of the network, and hands rate values to the readout/host logic over a valid/ready handshake.
- Windows run back-to-back while enabled. A one-entry output buffer decouples window timing from consumer stalls.

Parameters:
- W, 8, width of the window length, the spike counter and the rate output.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run decoding; deassertion aborts the current window.
- window_len  input  W  window length in cycles; 0 means 2^W; sampled only at window start.
- spike_in  input  1  spike from the neuron; one cycle high = one spike.
- rate_out  output  W  spike count of the last completed window.
- rate_valid  output  1  rate_out holds an unconsumed result.
- rate_ready  input  1  consumer accepts rate_out when rate_valid && rate_ready.
- overrun  output  1  sticky; a completed window result was dropped.
- busy  output  1  a window is in progress (FSM in COUNT).

Behaviour:
- Reset (rst=1 at a clk edge): FSM→IDLE; rate_out=0, rate_valid=0, overrun=0, busy=0; internal cycle and spike counters=0; latched length=0. Reset mid-window discards everything.
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- FSM state IDLE:
  - busy=0.
  - When enable=1, on the next edge: latch window_len into len_q, clear cyc and cnt, go to COUNT.
  - spike_in is ignored in IDLE, including on the transition cycle.
- FSM state COUNT:
  - busy=1.
  - Each cycle, cnt_next = cnt + spike_in, saturating at 2^W-1.
  - Terminal cycle: cyc == len_q-1, computed modulo 2^W, so len_q=0 terminates at cyc=2^W-1, giving a 2^W-cycle window.
  - The spike on the terminal cycle is counted.
  - On the terminal edge, result = cnt_next.
    - If enable=1: re-latch window_len, clear cyc and cnt, stay in COUNT. Windows are contiguous with no gap cycle.
    - If enable=0: go to IDLE.
  - If enable=0 on a non-terminal cycle: go to IDLE, discard the partial count, write no result.
- Window latency: the first window's first counted cycle is the cycle after enable is seen high in IDLE.
  - A window of N cycles spans COUNT cycles 0..N-1.
  - rate_valid rises in the cycle after the terminal edge, i.e. result is registered at the terminal edge.
- Output buffer:
  - A handshake completes at an edge where rate_valid && rate_ready.
  - A new result loads when rate_valid=0, or when a handshake completes at the same edge.
    - On load: rate_out=result, rate_valid=1.
    - A simultaneous handshake and load keeps rate_valid=1 with the new value.
  - Handshake with no new result: rate_valid→0; rate_out holds its last value.
  - New result while rate_valid=1 && rate_ready=0: result dropped, rate_out unchanged, overrun→1.
  - overrun clears only on rst.
  - rate_out and rate_valid do not change while rate_valid=1 && rate_ready=0, except through a handshake.
- Counter width:
  - cyc is W bits and wraps only through the terminal comparison.
  - cnt saturates at 2^W-1; this is reachable only when every cycle of a 2^W window spikes.
- window_len changes mid-window have no effect until the next window start.

Test Plan:
- Basic count: rst; window_len=10, enable=1; spike_in high on 3 cycles of the window; rate_ready=1 → rate_valid pulses 1 cycle, rate_out=3, exactly 11 cycles after enable first seen high; busy=1 throughout.
- Back-to-back windows: window_len=4, spikes every other cycle, continuous for 3 windows → three results of 2, spaced exactly 4 cycles apart. Terminal-cycle spike check: one spike only on a terminal cycle → that window reads 1.
- Full window and saturation: window_len=0 with spike_in=1 constantly → window is 256 cycles, rate_out=255 (saturated).
- Backpressure and overrun: window_len=5, rate_ready=0, 2 spikes per window for 2 windows → first result 2 held, overrun=1 after the second terminal edge. Then rate_ready=1 → 2 consumed, rate_valid=0, overrun stays 1 until rst.
- Handshake on the load edge: rate_valid=1 with value 7 and rate_ready=1 on the same edge as a terminal edge with result 4 → rate_valid stays 1, rate_out=4, overrun=0.
- Abort and reset: enable drops at cyc=6 of a 10-cycle window → IDLE, no result, busy=0. rst asserted mid-window with a pending result → all outputs 0 on the next cycle.
